system_cpu_mult_arbiter: RTL and testbench
==========================================

Name: system_cpu_mult_arbiter

Overview:
- Shares one pipelined 32x32->32 (low-word) multiplier cell between NUM_REQ requesters, e.g. the CPU A-stage and a custom-instruction / DSP-helper master.
- Round-robin arbitration, one operation issued per cycle, with a registered operand stage.
- A tag shift register tracks ownership through the cell's fixed latency and routes each result back to its owner as a one-cycle response pulse.
- Per-requester kill cancels that requester's in-flight operations.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- MUL_LATENCY, 1: clock cycles from cell operand inputs to cell result; the cell is never stalled.
- TAG_W, 2: width of the internal requester index; must satisfy 2**TAG_W >= NUM_REQ.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  grant; a transfer occurs when valid & ready are both high.
- req_src1  in  32*NUM_REQ  operand 1; requester i occupies bits [32i+31:32i].
- req_src2  in  32*NUM_REQ  operand 2; same packing as req_src1.
- req_kill  in  NUM_REQ  cancels all in-flight ops of requester i.
- rsp_valid  out  NUM_REQ  one-cycle result pulse to the owning requester.
- rsp_result  out  32  result; shared by all requesters, qualified by rsp_valid.
- mul_src1  out  32  registered operand 1 to the multiplier cell.
- mul_src2  out  32  registered operand 2 to the multiplier cell.
- mul_result  in  32  multiplier cell result, (src1*src2)[31:0].
- busy  out  1  high while any op is in the operand stage or in flight.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - req_ready, rsp_valid, rsp_result, mul_src1, mul_src2 = 0; busy = 0.
  - All pipeline valid/tag bits cleared; round-robin pointer = 0.
- Arbitration, combinational within a cycle:
  - Starting at pointer P, the first index i (modulo NUM_REQ) with req_valid[i]=1 and req_kill[i]=0 wins.
  - req_ready is one-hot on the winner, or all-zero if there is no winner.
  - After a grant, P <= winner+1 (mod NUM_REQ); otherwise P holds.
  - req_ready does not depend on downstream state: the pipeline never stalls, so one grant is possible every cycle.
- Issue stage (cycle 0 = grant edge):
  - mul_src1/mul_src2 <= winner's operands; s0_valid <= 1; s0_tag <= winner.
  - With no grant, s0_valid <= 0 and the operand registers hold their value (no toggling).
- Tag pipeline:
  - MUL_LATENCY stages of {valid, tag} follow s0, aligned to the cell.
  - Response appears at cycle 1+MUL_LATENCY after the grant edge (2 cycles at default).
- Response:
  - rsp_valid[tag] <= 1 for exactly one cycle; rsp_result <= mul_result, registered.
  - rsp_result holds its last value when no response is issued.
  - Responses return in issue order; at most one response per cycle.
- Arithmetic: low 32 bits only; the product wraps modulo 2^32, and signed and unsigned give identical low words. 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
- Kill:
  - req_kill[i] high in a cycle clears the valid bit of every stage (s0 and tag pipe) whose tag is i, at that clock edge.
  - The same requester cannot be granted in that cycle.
  - Ops of other requesters are unaffected.
  - If kill coincides with a response cycle for i, rsp_valid[i] is suppressed.
- busy = OR of s0_valid and all tag-pipe valid bits.
- Simultaneous requests: exactly one grant per cycle; a continuously asserting requester is granted at least once every NUM_REQ cycles.
- Reset mid-operation: all in-flight ops are discarded and no responses follow.
- A requester may drop req_valid without a grant; that is not an error.

Optional Feature:
- Macro SYSTEM_CPU_MULT_ARB_PERF_EN.
- When defined, adds output perf_grants (32, count of grants) and output perf_conflicts (32, cycles with >=2 eligible requesters).
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
  - Input perf_clear (1) synchronously zeroes both; clear has priority over increment in the same cycle.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single request: req0 src1=0x00001234, src2=0x00005678 -> req_ready[0] on cycle 0; rsp_valid[0] on cycle 2; rsp_result=0x06260060.
- Wrap: req1 src1=0xFFFFFFFF, src2=0xFFFFFFFF -> rsp_valid[1] on cycle 2, rsp_result=0x00000001.
- Contention: both requesters held valid for 6 cycles from reset -> grants 0,1,0,1,0,1; responses alternate on cycles 2..7 with correct products; busy high cycles 1..7.
- Kill: req0 granted on cycles 0 and 1, req1 granted on cycle 2, req_kill[0] pulsed on cycle 2 -> no rsp_valid[0] ever; rsp_valid[1] on cycle 4.
- Reset mid-op: grant on cycle 0, reset asserted on cycle 1 -> all outputs 0 immediately, no response after release, pointer = 0.
- PERF_EN: 3 contention cycles + 2 solo grants -> perf_grants=5, perf_conflicts=3; perf_clear -> both 0 next cycle.

Source files
------------

// File: rtl/system_cpu_mult_arbiter.sv
// Round-robin arbiter that shares one pipelined 32x32->32 multiplier cell between NUM_REQ requesters.
// Optional perf counters are enabled with the SYSTEM_CPU_MULT_ARB_PERF_EN macro.
module system_cpu_mult_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int MUL_LATENCY = 1,
  parameter int TAG_W       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_src1,
  input  logic [32*NUM_REQ-1:0]  req_src2,
  input  logic [NUM_REQ-1:0]     req_kill,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_result,
  output logic [31:0]            mul_src1,
  output logic [31:0]            mul_src2,
  input  logic [31:0]            mul_result,
  output logic                   busy
`ifdef SYSTEM_CPU_MULT_ARB_PERF_EN
  ,
  input  logic                   perf_clear,
  output logic [31:0]            perf_grants,
  output logic [31:0]            perf_conflicts
`endif
);

  localparam logic [TAG_W:0] LP_NUM = (TAG_W+1)'(NUM_REQ);

  logic [TAG_W-1:0]       r_ptr;
  logic [31:0]            r_mul_src1;
  logic [31:0]            r_mul_src2;
  logic                   r_s0_valid;
  logic [TAG_W-1:0]       r_s0_tag;
  logic [MUL_LATENCY-1:0] r_pipe_valid;
  logic [TAG_W-1:0]       r_pipe_tag [MUL_LATENCY];
  logic [NUM_REQ-1:0]     r_rsp_valid;
  logic [31:0]            r_rsp_result;

  logic [NUM_REQ-1:0]     w_eligible;
  logic [2*NUM_REQ-1:0]   w_dbl;
  logic [NUM_REQ-1:0]     w_rot;
  logic                   w_found;
  logic [TAG_W-1:0]       w_off;
  logic [TAG_W:0]         w_sum;
  logic [TAG_W:0]         w_inc;
  logic [TAG_W-1:0]       w_winner;
  logic [TAG_W-1:0]       w_ptr_next;
  logic [NUM_REQ-1:0]     w_grant;
  logic [31:0]            w_op1;
  logic [31:0]            w_op2;
  logic                   w_rsp_fire;

  function automatic logic killHit(input logic [NUM_REQ-1:0] kill, input logic [TAG_W-1:0] tag);
    return |(kill & (NUM_REQ'(1) << tag));
  endfunction

  assign w_eligible = req_valid & ~req_kill;
  assign w_dbl      = {w_eligible, w_eligible};
  // Rotate so the pointer's requester sits at bit 0; the lowest set bit is then the winner offset.
  assign w_rot      = NUM_REQ'(w_dbl >> r_ptr);
  assign w_found    = |w_rot;

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = TAG_W'(k);
    end
  end

  always_comb begin
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= LP_NUM) w_sum = w_sum - LP_NUM;
    w_winner = w_sum[TAG_W-1:0];
  end

  always_comb begin
    w_inc = {1'b0, w_winner} + (TAG_W+1)'(1);
    if (w_inc >= LP_NUM) w_inc = '0;
    w_ptr_next = w_inc[TAG_W-1:0];
  end

  assign w_grant = w_found ? (NUM_REQ'(1) << w_winner) : '0;

  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_op1 = req_src1[32*i +: 32];
        w_op2 = req_src2[32*i +: 32];
      end
    end
  end

  assign w_rsp_fire = r_pipe_valid[MUL_LATENCY-1] & ~killHit(req_kill, r_pipe_tag[MUL_LATENCY-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr        <= '0;
      r_mul_src1   <= '0;
      r_mul_src2   <= '0;
      r_s0_valid   <= 1'b0;
      r_s0_tag     <= '0;
      r_pipe_valid <= '0;
      for (int k = 0; k < MUL_LATENCY; k++) r_pipe_tag[k] <= '0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
    end else begin
      if (w_found) begin
        r_ptr      <= w_ptr_next;
        r_mul_src1 <= w_op1;
        r_mul_src2 <= w_op2;
        r_s0_tag   <= w_winner;
      end
      r_s0_valid <= w_found;
      // Each stage advances with the cell; a kill drops matching ops as they move.
      r_pipe_valid[0] <= r_s0_valid & ~killHit(req_kill, r_s0_tag);
      r_pipe_tag[0]   <= r_s0_tag;
      for (int k = 1; k < MUL_LATENCY; k++) begin
        r_pipe_valid[k] <= r_pipe_valid[k-1] & ~killHit(req_kill, r_pipe_tag[k-1]);
        r_pipe_tag[k]   <= r_pipe_tag[k-1];
      end
      r_rsp_valid <= w_rsp_fire ? (NUM_REQ'(1) << r_pipe_tag[MUL_LATENCY-1]) : '0;
      if (w_rsp_fire) r_rsp_result <= mul_result;
    end
  end

  assign req_ready  = reset ? '0 : w_grant;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign mul_src1   = r_mul_src1;
  assign mul_src2   = r_mul_src2;
  assign busy       = r_s0_valid | (|r_pipe_valid);

`ifdef SYSTEM_CPU_MULT_ARB_PERF_EN
  logic [31:0] r_perf_grants;
  logic [31:0] r_perf_conflicts;
  logic        w_conflict;

  assign w_conflict = |(w_eligible & (w_eligible - NUM_REQ'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_grants    <= '0;
      r_perf_conflicts <= '0;
    end else if (perf_clear) begin
      r_perf_grants    <= '0;
      r_perf_conflicts <= '0;
    end else begin
      if (w_found && (r_perf_grants != '1))       r_perf_grants    <= r_perf_grants + 32'd1;
      if (w_conflict && (r_perf_conflicts != '1)) r_perf_conflicts <= r_perf_conflicts + 32'd1;
    end
  end

  assign perf_grants    = r_perf_grants;
  assign perf_conflicts = r_perf_conflicts;
`endif

endmodule

// File: tb/tb_system_cpu_mult_arbiter.sv
// Directed self-checking bench for system_cpu_mult_arbiter with a one-cycle behavioural multiplier cell.
module tb_system_cpu_mult_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_src1 = '0;
  logic [63:0] req_src2 = '0;
  logic [1:0]  req_kill = '0;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_result;
  logic [31:0] mul_src1;
  logic [31:0] mul_src2;
  logic [31:0] mul_result = '0;
  logic        busy;
`ifdef SYSTEM_CPU_MULT_ARB_PERF_EN
  logic        perf_clear = 1'b0;
  logic [31:0] perf_grants;
  logic [31:0] perf_conflicts;
`endif

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] expProd [6];
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] killProd;

  system_cpu_mult_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_kill   (req_kill),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .mul_src1   (mul_src1),
    .mul_src2   (mul_src2),
    .mul_result (mul_result),
    .busy       (busy)
`ifdef SYSTEM_CPU_MULT_ARB_PERF_EN
    ,
    .perf_clear     (perf_clear),
    .perf_grants    (perf_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural multiplier cell: one cycle from operands to low-word product.
  always @(posedge clk) mul_result <= mul_src1 * mul_src2;

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] k,
                               input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1);
    req_valid = v;
    req_kill  = k;
    req_src1  = {a1, a0};
    req_src2  = {b1, b0};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
  endtask

  task automatic cycleEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, with requests pending to prove grants are held off
    applyStimulus(2'b11, 2'b00, 32'h1, 32'h1, 32'h2, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_result", rsp_result, 32'h0);
    checkOutput("rst_mul_src1", mul_src1, 32'h0);
    checkOutput("rst_mul_src2", mul_src2, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
    cycleEdge();

    $display("[TB] single request");
    applyStimulus(2'b01, 2'b00, 32'h0000_1234, 32'h0000_5678, 32'h0, 32'h0);
    #1 checkOutput("single_ready", 32'(req_ready), 32'h1);
    cycleEdge();
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    checkOutput("single_mul_src1", mul_src1, 32'h0000_1234);
    checkOutput("single_mul_src2", mul_src2, 32'h0000_5678);
    checkOutput("single_busy_c0", 32'(busy), 32'h1);
    cycleEdge();
    checkOutput("single_rsp_c1", 32'(rsp_valid), 32'h0);
    checkOutput("single_busy_c1", 32'(busy), 32'h1);
    cycleEdge();
    checkOutput("single_rsp_c2", 32'(rsp_valid), 32'h1);
    checkOutput("single_result", rsp_result, 32'h0626_0060);
    checkOutput("single_busy_c2", 32'(busy), 32'h0);
    cycleEdge();
    checkOutput("single_rsp_c3", 32'(rsp_valid), 32'h0);
    checkOutput("single_result_hold", rsp_result, 32'h0626_0060);
    checkOutput("single_src_hold", mul_src1, 32'h0000_1234);

    $display("[TB] wrap product");
    applyStimulus(2'b10, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1 checkOutput("wrap_ready", 32'(req_ready), 32'h2);
    cycleEdge();
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    checkOutput("wrap_mul_src1", mul_src1, 32'hFFFF_FFFF);
    cycleEdge();
    checkOutput("wrap_rsp_c1", 32'(rsp_valid), 32'h0);
    cycleEdge();
    checkOutput("wrap_rsp_c2", 32'(rsp_valid), 32'h2);
    checkOutput("wrap_result", rsp_result, 32'h0000_0001);
    cycleEdge();
    checkOutput("wrap_rsp_c3", 32'(rsp_valid), 32'h0);

    $display("[TB] contention");
    for (int j = 0; j < 8; j++) begin
      if (j < 6) begin
        opA = 32'h0001_0000 + 32'(j);
        opB = 32'h8000_0000 + 32'(j);
        expProd[j] = (j % 2 == 0) ? opA * 32'h3 : opB * 32'h2;
        applyStimulus(2'b11, 2'b00, opA, 32'h3, opB, 32'h2);
      end else begin
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      end
      #1 checkOutput("cont_ready", 32'(req_ready), (j < 6) ? ((j % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
      cycleEdge();
      if (j >= 2) begin
        checkOutput("cont_rsp_valid", 32'(rsp_valid), ((j - 2) % 2 == 0) ? 32'h1 : 32'h2);
        checkOutput("cont_result", rsp_result, expProd[j-2]);
      end else begin
        checkOutput("cont_rsp_idle", 32'(rsp_valid), 32'h0);
      end
      checkOutput("cont_busy", 32'(busy), (j <= 6) ? 32'h1 : 32'h0);
    end

    $display("[TB] kill");
    applyStimulus(2'b01, 2'b00, 32'h11, 32'h13, 32'h0, 32'h0);
    #1 checkOutput("kill_ready_g0", 32'(req_ready), 32'h1);
    cycleEdge();
    applyStimulus(2'b01, 2'b00, 32'h17, 32'h19, 32'h0, 32'h0);
    #1 checkOutput("kill_ready_g1", 32'(req_ready), 32'h1);
    cycleEdge();
    killProd = 32'h0000_0123 * 32'h0000_0321;
    applyStimulus(2'b11, 2'b01, 32'h1D, 32'h1F, 32'h0000_0123, 32'h0000_0321);
    #1 checkOutput("kill_ready_g2", 32'(req_ready), 32'h2);
    cycleEdge();
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    checkOutput("kill_rsp_c2", 32'(rsp_valid), 32'h0);
    cycleEdge();
    checkOutput("kill_rsp_c3", 32'(rsp_valid), 32'h0);
    cycleEdge();
    checkOutput("kill_rsp_c4", 32'(rsp_valid), 32'h2);
    checkOutput("kill_result", rsp_result, killProd);
    checkOutput("kill_busy_c4", 32'(busy), 32'h0);
    cycleEdge();
    checkOutput("kill_rsp_c5", 32'(rsp_valid), 32'h0);

    $display("[TB] reset mid-operation");
    applyStimulus(2'b01, 2'b00, 32'h5, 32'h7, 32'h0, 32'h0);
    #1 checkOutput("rmid_ready", 32'(req_ready), 32'h1);
    cycleEdge();
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    checkOutput("rmid_busy", 32'(busy), 32'h0);
    checkOutput("rmid_mul_src1", mul_src1, 32'h0);
    checkOutput("rmid_rsp_result", rsp_result, 32'h0);
    cycleEdge();
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cycleEdge();
      checkOutput("rmid_no_rsp", 32'(rsp_valid), 32'h0);
    end
    applyStimulus(2'b11, 2'b00, 32'h2, 32'h3, 32'h4, 32'h5);
    #1 checkOutput("rmid_ptr_zero", 32'(req_ready), 32'h1);
    cycleEdge();
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    cycleEdge();
    cycleEdge();
    checkOutput("rmid_after_rsp", 32'(rsp_valid), 32'h1);
    checkOutput("rmid_after_result", rsp_result, 32'h6);
    cycleEdge();

`ifdef SYSTEM_CPU_MULT_ARB_PERF_EN
    $display("[TB] perf counters");
    perf_clear = 1'b1;
    applyStimulus(2'b11, 2'b00, 32'h1, 32'h1, 32'h1, 32'h1);
    cycleEdge();
    perf_clear = 1'b0;
    checkOutput("perf_clear_prio_g", perf_grants, 32'h0);
    checkOutput("perf_clear_prio_c", perf_conflicts, 32'h0);
    repeat (3) cycleEdge();
    applyStimulus(2'b01, 2'b00, 32'h1, 32'h1, 32'h0, 32'h0);
    repeat (2) cycleEdge();
    applyStimulus(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    checkOutput("perf_grants", perf_grants, 32'd5);
    checkOutput("perf_conflicts", perf_conflicts, 32'd3);
    perf_clear = 1'b1;
    cycleEdge();
    perf_clear = 1'b0;
    checkOutput("perf_cleared_g", perf_grants, 32'h0);
    checkOutput("perf_cleared_c", perf_conflicts, 32'h0);
    repeat (3) cycleEdge();
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
